// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU execution unit:
//   - alu_op_e    : 3-bit opcode encoding presented on the op port
//   - alu_state_e : control FSM states of alu_exec_unit
//   - DATA_W_DEF / REG_ADDR_W_DEF : default operand and register-index widths
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int REG_ADDR_W_DEF = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        WB      = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
// Iterative unsigned shift-add multiplier, one partial product per cycle,
// DATA_W iterations after a start pulse. Only instantiated when the
// ALU_MUL_EN macro is defined.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (control state only)
//   i_start    in   load operands and begin; ignored while running
//   i_a, i_b   in   DATA_W unsigned operands, sampled on i_start
//   o_done     out  high during the last iteration cycle
//   o_product  out  2*DATA_W product, valid while o_done is high
// ---------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [DATA_W-1:0]     i_a,
    input  logic [DATA_W-1:0]     i_b,
    output logic                  o_done,
    output logic [2*DATA_W-1:0]   o_product
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    logic                 r_busy;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*DATA_W-1:0]  r_mcand;
    logic [DATA_W-1:0]    r_mplier;
    logic [2*DATA_W-1:0]  r_acc;
    logic [2*DATA_W-1:0]  w_acc_next;
    logic                 w_last;

    assign w_last     = r_busy && (r_cnt == LAST_ITER);
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // The final partial product is folded in combinationally so the owner
    // can capture the full product on the same edge that ends the run.
    assign o_done    = w_last;
    assign o_product = w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start && !r_busy) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
        end else if (r_busy) begin
            if (w_last) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_start && !r_busy) begin
            r_mcand  <= {{DATA_W{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Single-issue ALU execution unit feeding a register-file write port.
// Non-MUL ops write one cycle after acceptance; MUL runs an iterative
// multiplier for DATA_W cycles when the ALU_MUL_EN macro is defined,
// otherwise MUL completes in one cycle with a zero result.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid / in_ready    request handshake (accept when both high)
//   op                     opcode, alu_pkg::alu_op_e encoding
//   operand_a, operand_b   DATA_W source values
//   dest_reg               REG_ADDR_W destination index
//   reg_write              one-cycle write strobe
//   write_reg, write_data  write index and value, held between writes
//   flag_z, flag_c         zero / carry-borrow of the last written result
//
// Build option: define ALU_MUL_EN to include the iterative multiplier.
// ---------------------------------------------------------------------------
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_W-1:0]     operand_a,
    input  logic [DATA_W-1:0]     operand_b,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_data,
    output logic                  flag_z,
    output logic                  flag_c
);

    alu_state_e            r_state;
    alu_state_e            w_state_next;
    alu_op_e               w_op;
    logic                  w_accept;
    logic                  w_in_ready;
    logic                  w_reg_write;
    logic                  w_mul_start;
    logic                  w_mul_done;
    logic                  w_load;
    logic [DATA_W-1:0]     w_load_data;
    logic                  w_load_c;
    logic [REG_ADDR_W-1:0] w_load_reg;

    logic [DATA_W-1:0]     w_alu_res;
    logic                  w_alu_c;
    logic [DATA_W:0]       w_wide;
    logic [2:0]            w_shamt;

    logic [REG_ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0]     r_write_data;
    logic                  r_flag_z;
    logic                  r_flag_c;

    assign w_op     = alu_op_e'(op);
    assign w_shamt  = operand_b[2:0];
    // Decoded straight from the state register so accept does not loop
    // through the FSM output logic.
    assign w_accept = in_valid && (r_state != MUL_RUN);

    // Single-cycle ALU datapath
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_wide    = '0;
        case (w_op)
            OP_ADD: begin
                w_wide    = {1'b0, operand_a} + {1'b0, operand_b};
                w_alu_res = w_wide[DATA_W-1:0];
                w_alu_c   = w_wide[DATA_W];
            end
            OP_SUB: begin
                w_alu_res = operand_a - operand_b;
                w_alu_c   = (operand_a < operand_b);
            end
            OP_AND: w_alu_res = operand_a & operand_b;
            OP_OR:  w_alu_res = operand_a | operand_b;
            OP_XOR: w_alu_res = operand_a ^ operand_b;
            OP_SHL: begin
                // Extra MSB catches the last bit shifted out; stays 0 for amount 0.
                w_wide    = {1'b0, operand_a} << w_shamt;
                w_alu_res = w_wide[DATA_W-1:0];
                w_alu_c   = w_wide[DATA_W];
            end
            OP_SHR: begin
                // Extra LSB catches the last bit shifted out; stays 0 for amount 0.
                w_wide    = {operand_a, 1'b0} >> w_shamt;
                w_alu_res = w_wide[DATA_W:1];
                w_alu_c   = w_wide[0];
            end
            default: begin
                // MUL: zero result here; the multiplier path supplies it when built.
                w_alu_res = '0;
                w_alu_c   = 1'b0;
            end
        endcase
    end

`ifdef ALU_MUL_EN
    logic [2*DATA_W-1:0]   w_mul_prod;
    logic [REG_ADDR_W-1:0] r_mul_dest;

    assign w_mul_start = w_accept && (w_op == OP_MUL);

    alu_mul_seq #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_mul_start),
        .i_a       (operand_a),
        .i_b       (operand_b),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    // Destination is captured at acceptance because dest_reg may change
    // while the multiply runs.
    always_ff @(posedge clk) begin
        if (w_mul_start) begin
            r_mul_dest <= dest_reg;
        end
    end

    assign w_load      = (w_accept && !w_mul_start) || w_mul_done;
    assign w_load_data = w_mul_done ? w_mul_prod[DATA_W-1:0] : w_alu_res;
    assign w_load_c    = w_mul_done ? (|w_mul_prod[2*DATA_W-1:DATA_W]) : w_alu_c;
    assign w_load_reg  = w_mul_done ? r_mul_dest : dest_reg;
`else
    assign w_mul_start = 1'b0;
    assign w_mul_done  = 1'b0;
    assign w_load      = w_accept;
    assign w_load_data = w_alu_res;
    assign w_load_c    = w_alu_c;
    assign w_load_reg  = dest_reg;
`endif

    // Control FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Control FSM: next state and handshake/strobe outputs
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b1;
        w_reg_write  = 1'b0;
        case (r_state)
            IDLE, WB: begin
                w_reg_write = (r_state == WB);
                if (w_accept) begin
                    w_state_next = w_mul_start ? MUL_RUN : WB;
                end else begin
                    w_state_next = IDLE;
                end
            end
            MUL_RUN: begin
                w_in_ready   = 1'b0;
                w_state_next = w_mul_done ? WB : MUL_RUN;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Write-port registers: updated only on the edge that enters WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_flag_z     <= 1'b0;
            r_flag_c     <= 1'b0;
        end else if (w_load) begin
            r_write_reg  <= w_load_reg;
            r_write_data <= w_load_data;
            r_flag_z     <= (w_load_data == '0);
            r_flag_c     <= w_load_c;
        end
    end

    assign in_ready   = w_in_ready;
    assign reg_write  = w_reg_write;
    assign write_reg  = r_write_reg;
    assign write_data = r_write_data;
    assign flag_z     = r_flag_z;
    assign flag_c     = r_flag_c;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed self-checking bench for alu_exec_unit. Follows the ALU_MUL_EN
// build option of the design it is compiled with.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic [2:0] dest_reg;
    logic       reg_write;
    logic [2:0] write_reg;
    logic [7:0] write_data;
    logic       flag_z;
    logic       flag_c;

    int n_checks = 0;
    int n_errors = 0;

    alu_exec_unit #(
        .DATA_W     (8),
        .REG_ADDR_W (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .dest_reg   (dest_reg),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .flag_z     (flag_z),
        .flag_c     (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] d);
        in_valid  = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        dest_reg  = d;
    endtask

    task automatic expect_write(input string tag, input logic [2:0] r, input logic [7:0] data,
                                input logic z, input logic c);
        check({tag, "_we"},   32'(reg_write),  32'd1);
        check({tag, "_reg"},  32'(write_reg),  32'(r));
        check({tag, "_data"}, 32'(write_data), 32'(data));
        check({tag, "_z"},    32'(flag_z),     32'(z));
        check({tag, "_c"},    32'(flag_c),     32'(c));
    endtask

    task automatic expect_reset_outputs(input string tag);
        check({tag, "_we"},    32'(reg_write),  32'd0);
        check({tag, "_reg"},   32'(write_reg),  32'd0);
        check({tag, "_data"},  32'(write_data), 32'd0);
        check({tag, "_z"},     32'(flag_z),     32'd0);
        check({tag, "_c"},     32'(flag_c),     32'd0);
        check({tag, "_ready"}, 32'(in_ready),   32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'd0;
        operand_a = 8'h00;
        operand_b = 8'h00;
        dest_reg  = 3'd0;

        // Reset state
        tick();
        tick();
        expect_reset_outputs("rst");
        rst_n = 1'b1;
        tick();
        expect_reset_outputs("post_rst");

        // ADD with carry out
        issue(OP_ADD, 8'hF0, 8'h20, 3'd3);
        tick();
        expect_write("add", 3'd3, 8'h10, 1'b0, 1'b1);

        // Back-to-back SUBs: equal operands, then borrow
        issue(OP_SUB, 8'h05, 8'h05, 3'd1);
        tick();
        expect_write("sub_eq", 3'd1, 8'h00, 1'b1, 1'b0);
        issue(OP_SUB, 8'h03, 8'h05, 3'd2);
        tick();
        expect_write("sub_bw", 3'd2, 8'hFE, 1'b0, 1'b1);

        // No request: strobe drops, outputs hold
        in_valid = 1'b0;
        tick();
        check("idle_we",    32'(reg_write),  32'd0);
        check("idle_ready", 32'(in_ready),   32'd1);
        check("idle_data",  32'(write_data), 32'hFE);
        check("idle_c",     32'(flag_c),     32'd1);

        // Logic ops clear carry
        issue(OP_AND, 8'hF0, 8'h0F, 3'd4);
        tick();
        expect_write("and", 3'd4, 8'h00, 1'b1, 1'b0);
        issue(OP_OR, 8'hA0, 8'h05, 3'd5);
        tick();
        expect_write("or", 3'd5, 8'hA5, 1'b0, 1'b0);
        issue(OP_XOR, 8'hFF, 8'h0F, 3'd6);
        tick();
        expect_write("xor", 3'd6, 8'hF0, 1'b0, 1'b0);

        // Shifts: carry is last bit out, amount from operand_b[2:0]
        issue(OP_SHL, 8'h81, 8'h01, 3'd1);
        tick();
        expect_write("shl1", 3'd1, 8'h02, 1'b0, 1'b1);
        issue(OP_SHR, 8'h81, 8'h00, 3'd2);
        tick();
        expect_write("shr0", 3'd2, 8'h81, 1'b0, 1'b0);
        issue(OP_SHR, 8'h81, 8'h09, 3'd3);
        tick();
        expect_write("shr9", 3'd3, 8'h40, 1'b0, 1'b1);
        issue(OP_SHL, 8'h03, 8'h07, 3'd4);
        tick();
        expect_write("shl7", 3'd4, 8'h80, 1'b0, 1'b1);

        // ADD wrapping to zero
        issue(OP_ADD, 8'hFF, 8'h01, 3'd7);
        tick();
        expect_write("add_wrap", 3'd7, 8'h00, 1'b1, 1'b1);
        in_valid = 1'b0;
        tick();

`ifdef ALU_MUL_EN
        // Iterative MUL: busy for 8 cycles, requests during busy ignored
        issue(OP_MUL, 8'h10, 8'h11, 3'd5);
        tick();
        issue(OP_ADD, 8'h01, 8'h01, 3'd6);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("mul_busy_ready_%0d", i), 32'(in_ready),  32'd0);
            check($sformatf("mul_busy_we_%0d", i),    32'(reg_write), 32'd0);
            if (i == 8) in_valid = 1'b0;
            tick();
        end
        expect_write("mul", 3'd5, 8'h10, 1'b0, 1'b1);
        check("mul_wb_ready", 32'(in_ready), 32'd1);
        tick();
        check("mul_after_we",  32'(reg_write), 32'd0);
        check("mul_after_reg", 32'(write_reg), 32'd5);

        // Reset in the middle of a multiply aborts it
        issue(OP_MUL, 8'h10, 8'h11, 3'd6);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mulrst_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        expect_reset_outputs("mulrst");
`else
        // MUL without the multiplier: single-cycle zero result
        issue(OP_MUL, 8'h03, 8'h04, 3'd5);
        tick();
        expect_write("mul_off", 3'd5, 8'h00, 1'b1, 1'b0);
        check("mul_off_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        tick();
        check("mul_off_after_we", 32'(reg_write), 32'd0);

        // Reset after a nonzero write clears everything
        issue(OP_ADD, 8'h12, 8'h34, 3'd4);
        tick();
        expect_write("pre_rst", 3'd4, 8'h46, 1'b0, 1'b0);
        issue(OP_XOR, 8'h55, 8'h0F, 3'd2);
        #2;
        rst_n = 1'b0;
        #1;
        expect_reset_outputs("midrst");
        in_valid = 1'b0;
`endif

        tick();
        tick();
        rst_n = 1'b1;
        tick();
        expect_reset_outputs("rel");
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("no_write_%0d", i), 32'(reg_write), 32'd0);
        end
        check("final_ready", 32'(in_ready),   32'd1);
        check("final_data",  32'(write_data), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width.
REQ-002 SHALL have parameter REG_ADDR_W, default 3, destination register index width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-007 SHALL have port op  input  3  opcode (package enum).
REQ-008 SHALL have port operand_a  input  DATA_W  first source value, from register-file read port 1.
REQ-009 SHALL have port operand_b  input  DATA_W  second source value, from register-file read port 2.
REQ-010 SHALL have port dest_reg  input  REG_ADDR_W  destination register index.
REQ-011 SHALL have port reg_write  output  1  one-cycle register-file write strobe.
REQ-012 SHALL have port write_reg  output  REG_ADDR_W  register-file write index.
REQ-013 SHALL have port write_data  output  DATA_W  register-file write value.
REQ-014 SHALL have port flag_z  output  1  registered zero flag of the last written result.
REQ-015 SHALL have port flag_c  output  1  registered carry/borrow flag of the last written result.

Function
REQ-016 Opcodes SHALL be ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, MUL=7.
REQ-017 FSM SHALL have states IDLE, MUL_RUN, WB.
REQ-018 in_ready SHALL be 1 in IDLE and WB, 0 in MUL_RUN; a request is accepted on an edge where in_valid and in_ready are both 1.
REQ-019 Accepted non-MUL op SHALL latch result, dest_reg and flags, go to WB; reg_write=1 exactly the following cycle (latency 1).
REQ-020 Accepted MUL SHALL go to MUL_RUN, run 8 shift-add iterations (counter 0..7, one per cycle), then WB; reg_write=1 on cycle 9 after acceptance.
REQ-021 WB with no accepted request SHALL return to IDLE; WB accepting a request SHALL behave as IDLE accepting it (back-to-back, one write per cycle).
REQ-022 ADD carry SHALL be bit DATA_W of the sum; SUB result is a-b mod 2^DATA_W, flag_c=1 iff a<b unsigned.
REQ-023 AND/OR/XOR SHALL set flag_c=0.
REQ-024 SHL/SHR amount SHALL be operand_b[2:0], zero fill; flag_c = last bit shifted out, 0 when amount is 0.
REQ-025 MUL result SHALL be low DATA_W bits of unsigned product; flag_c=1 iff high DATA_W bits nonzero.
REQ-026 flag_z SHALL be 1 iff write_data==0; flags and write_reg/write_data SHALL update only when entering WB and hold otherwise.
REQ-027 in_valid while in_ready=0 SHALL be ignored; requester holds it.

Reset
REQ-028 rst_n low SHALL force IDLE, counter 0, reg_write=0, write_reg=0, write_data=0, flag_z=0, flag_c=0, in_ready=1 next after release.
REQ-029 Reset during MUL_RUN SHALL abort the multiply with no write ever issued.

Configuration
REQ-030 Macro ALU_MUL_EN defined SHALL include MUL_RUN and the iterative multiplier per REQ-020/025.
REQ-031 Without ALU_MUL_EN, MUL SHALL complete with latency 1, write_data=0, flag_c=0, flag_z=1; MUL_RUN unreachable and no multiplier logic present.

Structure
REQ-032 Shared package alu_pkg SHALL hold the opcode enum, the FSM state enum and DATA_W/REG_ADDR_W defaults.
REQ-033 Iterative multiplier SHALL be sub-module alu_mul_seq (start, done, 8-cycle shift-add), instantiated only under ALU_MUL_EN.

Verification
REQ-034 ADD a=0xF0 b=0x20 dest=3 -> next cycle reg_write=1, write_reg=3, write_data=0x10, flag_c=1, flag_z=0.
REQ-035 SUB a=0x05 b=0x05 then SUB a=0x03 b=0x05 back-to-back -> writes 0x00 (z=1,c=0) then 0xFE (z=0,c=1) on consecutive cycles.
REQ-036 SHL a=0x81 b=0x01 -> 0x02, c=1; SHR a=0x81 b=0x00 -> 0x81, c=0.
REQ-037 MUL a=0x10 b=0x11 (ALU_MUL_EN) -> in_ready=0 8 cycles, write 0x10 with c=1 on cycle 9; in_valid during busy ignored.
REQ-038 MUL started, rst_n low at iteration 4 -> no reg_write, all outputs 0, in_ready=1 after release.
REQ-039 MUL a=0x03 b=0x04 without ALU_MUL_EN -> next cycle write_data=0x00, z=1, c=0.
